// File: rtl/seg_disp_pkg.sv
// Shared constants and types for the multiplexed 7-segment display path.
// Anode and decimal-point lines are active-low, so their idle level is 1.
package seg_disp_pkg;

   localparam int unsigned SEG_DIGIT_W   = 4;
   localparam logic        AN_OFF        = 1'b1;
   localparam logic        DP_OFF        = 1'b1;
   localparam int unsigned SCAN_DIV_DEF  = 50000;
   localparam int unsigned BLANK_CYC_DEF = 16;

   typedef logic [SEG_DIGIT_W-1:0] seg_digit_t;

endpackage

// File: rtl/scan_tick_gen.sv
// Per-digit slot divider: counts 0..SCAN_DIV-1 while running and flags
// the slot start, slot end and the anti-ghosting blank window.
import seg_disp_pkg::*;

module scan_tick_gen #(
   parameter int unsigned SCAN_DIV  = SCAN_DIV_DEF,
   parameter int unsigned BLANK_CYC = BLANK_CYC_DEF
) (
   input  logic clk,
   input  logic clear,
   input  logic run,
   output logic slot_start,
   output logic slot_end,
   output logic blank
);

   localparam int unsigned CNT_W = $clog2(SCAN_DIV);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign slot_start = (cnt_q == '0);
   assign slot_end   = (cnt_q == CNT_W'(SCAN_DIV - 1));
   assign blank      = (32'(cnt_q) < BLANK_CYC);

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode display scanner: frame snapshot, digit
// stepping, leading-zero suppression and registered anode/dp/value outputs.
import seg_disp_pkg::*;

module seven_seg_scan #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned SCAN_DIV   = SCAN_DIV_DEF,
   parameter int unsigned BLANK_CYC  = BLANK_CYC_DEF
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              enable,
   input  logic [SEG_DIGIT_W*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]             dp_mask,
   input  logic                              lz_en,
   output seg_digit_t                        val,
   output logic                              dp_n,
   output logic [NUM_DIGITS-1:0]             an_n,
   output logic                              frame_tick
);

   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0] state_q, state_d;
   logic       run_q;
   logic       tick_clear;
   logic       slot_start, slot_end, blank;

   logic [IDX_W-1:0]                idx_q, idx_d;
   logic [SEG_DIGIT_W*NUM_DIGITS-1:0] snap_dig_q, cur_dig;
   logic [NUM_DIGITS-1:0]           snap_dp_q, cur_dp;
   logic                            snap_load;
   logic [NUM_DIGITS-1:0]           supp;
   logic                            tail_zero;
   seg_digit_t                      cur_val;
   logic                            drive;

   seg_digit_t            val_d;
   logic                  dp_n_d;
   logic [NUM_DIGITS-1:0] an_n_d;
   logic                  frame_tick_d;

   assign run_q      = (state_q == ST_RUN);
   assign state_d    = enable ? ST_RUN : ST_IDLE;
   assign tick_clear = rst | ~enable;

   scan_tick_gen #(
      .SCAN_DIV  (SCAN_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) u_tick (
      .clk        (clk),
      .clear      (tick_clear),
      .run        (run_q),
      .slot_start (slot_start),
      .slot_end   (slot_end),
      .blank      (blank)
   );

   always_comb begin
      idx_d = idx_q;
      if (tick_clear) begin
         idx_d = '0;
      end else if (run_q && slot_end) begin
         idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end
   end

   // The loading cycle already displays the freshly captured frame.
   assign snap_load = run_q && slot_start && (idx_q == '0);
   assign cur_dig   = snap_load ? digits  : snap_dig_q;
   assign cur_dp    = snap_load ? dp_mask : snap_dp_q;

   always_comb begin
      supp      = '0;
      tail_zero = lz_en;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         tail_zero = tail_zero && (cur_dig[i*SEG_DIGIT_W +: SEG_DIGIT_W] == '0) && !cur_dp[i];
         supp[i]   = tail_zero;
      end
   end

   assign cur_val = cur_dig[int'(idx_q)*SEG_DIGIT_W +: SEG_DIGIT_W];
   assign drive   = run_q && !blank && !supp[idx_q];

   always_comb begin
      an_n_d = {NUM_DIGITS{AN_OFF}};
      if (drive) begin
         an_n_d[idx_q] = ~AN_OFF;
      end
      val_d        = run_q ? cur_val : '0;
      dp_n_d       = drive ? ~cur_dp[idx_q] : DP_OFF;
      frame_tick_d = snap_load;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         snap_dig_q <= '0;
         snap_dp_q  <= '0;
         val        <= '0;
         dp_n       <= DP_OFF;
         an_n       <= {NUM_DIGITS{AN_OFF}};
         frame_tick <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         snap_dig_q <= cur_dig;
         snap_dp_q  <= cur_dp;
         val        <= val_d;
         dp_n       <= dp_n_d;
         an_n       <= an_n_d;
         frame_tick <= frame_tick_d;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed plus randomized bench for seven_seg_scan, checked every cycle
// against a position-in-frame reference model.
module tb_seven_seg_scan;

   localparam int ND = 4;
   localparam int SD = 8;
   localparam int BC = 2;
   localparam int FRAME = ND * SD;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [15:0]   digits;
   logic [3:0]    dp_mask;
   logic          lz_en;
   logic [3:0]    val;
   logic          dp_n;
   logic [3:0]    an_n;
   logic          frame_tick;

   int n_err    = 0;
   int n_checks = 0;

   // Reference model state: running flag and cycle position within the run.
   bit          m_run = 1'b0;
   int          m_pos = 0;
   logic [15:0] m_snap_dig = '0;
   logic [3:0]  m_snap_dp  = '0;
   logic [3:0]  exp_an, exp_val;
   logic        exp_dp, exp_ft;

   always #5 clk = ~clk;

   seven_seg_scan #(
      .NUM_DIGITS (ND),
      .SCAN_DIV   (SD),
      .BLANK_CYC  (BC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .digits     (digits),
      .dp_mask    (dp_mask),
      .lz_en      (lz_en),
      .val        (val),
      .dp_n       (dp_n),
      .an_n       (an_n),
      .frame_tick (frame_tick)
   );

   function automatic bit is_suppressed(int s);
      if (s == 0 || !lz_en) return 1'b0;
      for (int j = s; j < ND; j++) begin
         if (m_snap_dig[j*4 +: 4] != 4'h0 || m_snap_dp[j]) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Expected outputs after the coming edge, from the inputs seen before it.
   task automatic model_edge();
      int slot, off;
      exp_an  = 4'hF;
      exp_val = 4'h0;
      exp_dp  = 1'b1;
      exp_ft  = 1'b0;
      if (rst) begin
         m_run = 1'b0;
         m_pos = 0;
      end else if (m_run) begin
         if (m_pos % FRAME == 0) begin
            m_snap_dig = digits;
            m_snap_dp  = dp_mask;
            exp_ft     = 1'b1;
         end
         slot    = (m_pos / SD) % ND;
         off     = m_pos % SD;
         exp_val = m_snap_dig[slot*4 +: 4];
         if (off >= BC && !is_suppressed(slot)) begin
            exp_an       = 4'hF;
            exp_an[slot] = 1'b0;
            exp_dp       = ~m_snap_dp[slot];
         end
         m_pos = enable ? m_pos + 1 : 0;
         m_run = enable;
      end else begin
         m_run = enable;
         m_pos = 0;
      end
   endtask

   task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, expv);
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check("an_n", 32'(an_n), 32'(exp_an));
      check("val", 32'(val), 32'(exp_val));
      check("dp_n", 32'(dp_n), 32'(exp_dp));
      check("frame_tick", 32'(frame_tick), 32'(exp_ft));
      check("one_anode", 32'($countones(~an_n) <= 1), 32'd1);
   endtask

   task automatic run_cycles(int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      rst     = 1'b1;
      enable  = 1'b1;
      digits  = 16'h1234;
      dp_mask = 4'h0;
      lz_en   = 1'b0;

      // Reset held with enable high.
      run_cycles(3);
      rst = 1'b0;

      // First pulse on the second edge after release, then first drive cycle.
      run_cycles(2);
      check("first_tick", 32'(frame_tick), 32'd1);
      run_cycles(2);
      check("slot0_an", 32'(an_n), 32'(4'b1110));
      check("slot0_val", 32'(val), 32'd4);
      run_cycles(2 * FRAME);

      // Leading-zero suppression.
      lz_en  = 1'b1;
      digits = 16'h0040;
      run_cycles(2 * FRAME);
      digits = 16'h0000;
      run_cycles(2 * FRAME);
      digits  = 16'h0012;
      dp_mask = 4'b0100;
      run_cycles(2 * FRAME);

      // Mid-frame input change waits for the next frame.
      lz_en   = 1'b0;
      dp_mask = 4'h0;
      digits  = 16'h1234;
      run_cycles(FRAME + 12);
      digits = 16'h5678;
      run_cycles(2 * FRAME);

      // Enable dropped mid-slot 2, re-asserted, then reset mid-frame.
      run_cycles(FRAME - ((2 * FRAME + FRAME + 12) % FRAME) + 2 * SD + 3);
      enable = 1'b0;
      run_cycles(6);
      enable = 1'b1;
      digits = 16'h9A0B;
      run_cycles(FRAME + 13);
      rst = 1'b1;
      run_cycles(2);
      rst = 1'b0;
      run_cycles(FRAME + 5);

      // Randomized segments with mid-frame input changes.
      for (int f = 0; f < 60; f++) begin
         int r;
         r = int'($urandom_range(0, 19));
         for (int k = 0; k < ND; k++) begin
            digits[k*4 +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
         end
         dp_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         lz_en   = 1'($urandom_range(0, 1));
         enable  = (r != 0);
         rst     = (r == 19);
         run_cycles(int'($urandom_range(1, 40)));
      end
      rst    = 1'b0;
      enable = 1'b1;
      run_cycles(FRAME);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
